tdp_ram36k_march_bist: RTL and testbench

- Single-port test initiator that drives the write/read side of one TDP_RAM36K port: WEN, REN, BE, ADDR and WDATA, and checks the returned RDATA.
- Runs a March C- sequence over a configurable word range and reports pass/fail, first failing address/element and an error count.
- Sits between the RAM port and a test/control register block; the functional user path is muxed off externally while BUSY=1.

---
 rtl/tdp_ram36k_march_bist.sv | 182 ++++++++++++++++++
 tb/tb_tdp_ram36k_march_bist.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdp_ram36k_march_bist.sv
// March C- BIST initiator for one TDP_RAM36K port: drives WEN/REN/BE/ADDR/WDATA,
// checks RDATA and reports done/fail, first failing address/element and an error count.
module tdp_ram36k_march_bist #(
  parameter int DATA_WIDTH   = 36,
  parameter int ADDR_WIDTH   = 10,
  parameter int ADDR_LSB     = 5,
  parameter int READ_LATENCY = 1
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  START,
  input  logic                  ABORT,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  FAIL,
  output logic [ADDR_WIDTH-1:0] FAIL_ADDR,
  output logic [2:0]            FAIL_ELEM,
  output logic [7:0]            ERR_COUNT,
  output logic                  WEN,
  output logic                  REN,
  output logic [3:0]            BE,
  output logic [14:0]           ADDR,
  output logic [DATA_WIDTH-1:0] WDATA,
  input  logic [DATA_WIDTH-1:0] RDATA
);

  if (DATA_WIDTH < 1 || DATA_WIDTH > 36) begin : g_bad_data_width
    $fatal(1, "tdp_ram36k_march_bist: DATA_WIDTH=%0d out of range 1..36", DATA_WIDTH);
  end
  if (ADDR_WIDTH < 1 || ADDR_WIDTH > 24) begin : g_bad_addr_width
    $fatal(1, "tdp_ram36k_march_bist: ADDR_WIDTH=%0d out of range 1..24", ADDR_WIDTH);
  end
  if (ADDR_LSB < 0 || ADDR_LSB > 15) begin : g_bad_addr_lsb
    $fatal(1, "tdp_ram36k_march_bist: ADDR_LSB=%0d out of range 0..15", ADDR_LSB);
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 3) begin : g_bad_read_latency
    $fatal(1, "tdp_ram36k_march_bist: READ_LATENCY=%0d out of range 1..3", READ_LATENCY);
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_WT,
    S_CMP,
    S_FIN
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;
  localparam int WT_LAST = (READ_LATENCY > 1) ? READ_LATENCY - 2 : 0;

  state_t                state, state_nx;
  logic [2:0]            elem, elem_nx;
  logic [ADDR_WIDTH-1:0] waddr, waddr_nx;
  logic [1:0]            wt_cnt, wt_cnt_nx;
  logic                  wen_c, ren_c;
  logic                  elem_down, last_addr, active, miscompare;
  logic [DATA_WIDTH-1:0] exp_pat, wr_pat;

  assign elem_down = (elem >= 3'd3);
  assign last_addr = elem_down ? (waddr == '0) : (waddr == ADDR_MAX);
  assign active    = (state == S_WR) || (state == S_RD) || (state == S_WT) || (state == S_CMP);

  // E2/E4 read back ones, everything else reads zeros; E1/E3 write ones.
  assign exp_pat = ((elem == 3'd2) || (elem == 3'd4)) ? '1 : '0;
  assign wr_pat  = ((elem == 3'd1) || (elem == 3'd3)) ? '1 : '0;

  assign miscompare = (state == S_CMP) && !ABORT && (RDATA != exp_pat);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state  <= S_IDLE;
      elem   <= '0;
      waddr  <= '0;
      wt_cnt <= '0;
    end else begin
      state  <= state_nx;
      elem   <= elem_nx;
      waddr  <= waddr_nx;
      wt_cnt <= wt_cnt_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    elem_nx   = elem;
    waddr_nx  = waddr;
    wt_cnt_nx = wt_cnt;
    wen_c     = 1'b0;
    ren_c     = 1'b0;
    case (state)
      S_IDLE: begin
        if (START) begin
          state_nx = S_WR;
          elem_nx  = '0;
          waddr_nx = '0;
        end
      end
      S_WR: begin
        wen_c = 1'b1;
        if (last_addr) begin
          state_nx = S_RD;
          elem_nx  = 3'd1;
          waddr_nx = '0;
        end else begin
          waddr_nx = waddr + ADDR_WIDTH'(1);
        end
      end
      S_RD: begin
        ren_c     = 1'b1;
        wt_cnt_nx = '0;
        state_nx  = (READ_LATENCY > 1) ? S_WT : S_CMP;
      end
      S_WT: begin
        if (wt_cnt == 2'(WT_LAST)) begin
          state_nx = S_CMP;
        end else begin
          wt_cnt_nx = wt_cnt + 2'd1;
        end
      end
      S_CMP: begin
        wen_c = (elem != 3'd5);
        if (last_addr) begin
          if (elem == 3'd5) begin
            state_nx = S_FIN;
          end else begin
            state_nx = S_RD;
            elem_nx  = elem + 3'd1;
            waddr_nx = (elem >= 3'd2) ? ADDR_MAX : '0;
          end
        end else begin
          state_nx = S_RD;
          waddr_nx = elem_down ? waddr - ADDR_WIDTH'(1) : waddr + ADDR_WIDTH'(1);
        end
      end
      S_FIN: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    // START only counts in IDLE, so ABORT takes priority whenever the test is running.
    if (ABORT && (state != S_IDLE)) begin
      state_nx = S_IDLE;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      DONE      <= 1'b0;
      FAIL      <= 1'b0;
      FAIL_ADDR <= '0;
      FAIL_ELEM <= '0;
      ERR_COUNT <= '0;
    end else if ((state == S_IDLE) && START) begin
      DONE      <= 1'b0;
      FAIL      <= 1'b0;
      FAIL_ADDR <= '0;
      FAIL_ELEM <= '0;
      ERR_COUNT <= '0;
    end else begin
      if ((state == S_FIN) && !ABORT) begin
        DONE <= 1'b1;
      end
      if (miscompare) begin
        if (ERR_COUNT != 8'hFF) begin
          ERR_COUNT <= ERR_COUNT + 8'd1;
        end
        if (!FAIL) begin
          FAIL      <= 1'b1;
          FAIL_ADDR <= waddr;
          FAIL_ELEM <= elem;
        end
      end
    end
  end

  assign BUSY  = (state != S_IDLE);
  assign WEN   = wen_c;
  assign REN   = ren_c;
  assign BE    = wen_c ? 4'hF : 4'h0;
  assign ADDR  = active ? 15'(64'(waddr) << ADDR_LSB) : '0;
  assign WDATA = wen_c ? wr_pat : '0;

endmodule

// File: tb/tb_tdp_ram36k_march_bist.sv
// Bench for tdp_ram36k_march_bist: two instances (read latency 1 and 3) on behavioural
// RAMs with injectable stuck-at bits, checked against a march-level access/result model.
module tb_tdp_ram36k_march_bist;

  localparam int DW  = 36;
  localparam int AW  = 4;
  localparam int D   = 16;
  localparam int LSB = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, abort;
  logic          busy[2], done[2], fail[2], wen[2], ren[2];
  logic [AW-1:0] fail_addr[2];
  logic [2:0]    fail_elem[2];
  logic [7:0]    err_count[2];
  logic [3:0]    be[2];
  logic [14:0]   addr[2];
  logic [DW-1:0] wdata[2], rdata[2];

  tdp_ram36k_march_bist #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ADDR_LSB(LSB), .READ_LATENCY(1)) dut0 (
    .CLK(clk), .RESET_N(rst_n), .START(start), .ABORT(abort),
    .BUSY(busy[0]), .DONE(done[0]), .FAIL(fail[0]), .FAIL_ADDR(fail_addr[0]),
    .FAIL_ELEM(fail_elem[0]), .ERR_COUNT(err_count[0]), .WEN(wen[0]), .REN(ren[0]),
    .BE(be[0]), .ADDR(addr[0]), .WDATA(wdata[0]), .RDATA(rdata[0])
  );

  tdp_ram36k_march_bist #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ADDR_LSB(LSB), .READ_LATENCY(3)) dut1 (
    .CLK(clk), .RESET_N(rst_n), .START(start), .ABORT(abort),
    .BUSY(busy[1]), .DONE(done[1]), .FAIL(fail[1]), .FAIL_ADDR(fail_addr[1]),
    .FAIL_ELEM(fail_elem[1]), .ERR_COUNT(err_count[1]), .WEN(wen[1]), .REN(ren[1]),
    .BE(be[1]), .ADDR(addr[1]), .WDATA(wdata[1]), .RDATA(rdata[1])
  );

  // Behavioural RAMs; faulty words return f_val on bit f_bit regardless of contents.
  logic [DW-1:0] mem0[D], mem1[D];
  logic [DW-1:0] pipe0, pipe1a, pipe1b, pipe1c;
  bit            f_en;
  logic [D-1:0]  f_mask;
  int            f_bit;
  bit            f_val;

  always @(posedge clk) begin : ram_model
    logic [DW-1:0] d;
    logic [AW-1:0] w;
    w = addr[0][LSB+AW-1:LSB];
    if (wen[0]) mem0[w] <= wdata[0];
    if (ren[0]) begin
      d = mem0[w];
      if (f_en && f_mask[w]) d[f_bit] = f_val;
      pipe0 <= d;
    end
    w = addr[1][LSB+AW-1:LSB];
    if (wen[1]) mem1[w] <= wdata[1];
    if (ren[1]) begin
      d = mem1[w];
      if (f_en && f_mask[w]) d[f_bit] = f_val;
      pipe1a <= d;
    end
    pipe1b <= pipe1a;
    pipe1c <= pipe1b;
  end
  assign rdata[0] = pipe0;
  assign rdata[1] = pipe1c;

  int sel;
  logic          o_busy, o_done, o_fail, o_wen, o_ren;
  logic [AW-1:0] o_fail_addr;
  logic [2:0]    o_fail_elem;
  logic [7:0]    o_err;
  logic [3:0]    o_be;
  logic [14:0]   o_addr;
  logic [DW-1:0] o_wdata;
  assign o_busy = busy[sel];
  assign o_done = done[sel];
  assign o_fail = fail[sel];
  assign o_wen  = wen[sel];
  assign o_ren  = ren[sel];
  assign o_fail_addr = fail_addr[sel];
  assign o_fail_elem = fail_elem[sel];
  assign o_err   = err_count[sel];
  assign o_be    = be[sel];
  assign o_addr  = addr[sel];
  assign o_wdata = wdata[sel];

  int total = 0;
  int bad   = 0;

  typedef struct { bit wr; int word; int elem; } acc_t;

  function automatic int busy_len(input int rl);
    return D + 5 * D * (rl + 1) + 1;
  endfunction

  // Pulses START, then follows the selected instance cycle by cycle, checking every RAM
  // access against the march access list and read-to-write spacing against the latency.
  task automatic run_march(input int restart_at, input int abort_at, output int cycles);
    acc_t q[$];
    acc_t e;
    int last_ren, rl, wait_cnt;
    logic [20:0] exp_v, obs_v;
    logic [DW-1:0] wexp;
    rl = (sel == 1) ? 3 : 1;
    for (int a = 0; a < D; a++) q.push_back('{1'b1, a, 0});
    for (int el = 1; el <= 5; el++) begin
      for (int i = 0; i < D; i++) begin
        int a;
        a = (el >= 3) ? D - 1 - i : i;
        q.push_back('{1'b0, a, el});
        if (el < 5) q.push_back('{1'b1, a, el});
      end
    end
    wait_cnt = 0;
    while ((busy[0] !== 1'b0 || busy[1] !== 1'b0) && wait_cnt < 500) begin
      @(negedge clk);
      wait_cnt++;
    end
    total++;
    if (wait_cnt >= 500) begin
      bad++;
      $display("FAIL idle_wait: busy0=%0b busy1=%0b required 0 0", busy[0], busy[1]);
    end
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cycles = 0;
    last_ren = -1000;
    while (o_busy === 1'b1 && cycles < 4000) begin
      if (o_wen === 1'b1 || o_ren === 1'b1) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL extra_access: cycle %0d wen=%0b ren=%0b addr=%0h required none", cycles, o_wen, o_ren, o_addr);
        end else begin
          e = q.pop_front();
          exp_v = {e.wr, ~e.wr, e.wr ? 4'hF : 4'h0, 15'(e.word << LSB)};
          obs_v = {o_wen, o_ren, o_be, o_addr};
          if (obs_v !== exp_v) begin
            bad++;
            $display("FAIL access: cycle %0d elem %0d {wen,ren,be,addr}=%h required %h", cycles, e.elem, obs_v, exp_v);
          end
          if (e.wr) begin
            wexp = (e.elem == 1 || e.elem == 3) ? '1 : '0;
            total++;
            if (o_wdata !== wexp) begin
              bad++;
              $display("FAIL wdata: cycle %0d elem %0d got %h required %h", cycles, e.elem, o_wdata, wexp);
            end
            if (e.elem > 0) begin
              total++;
              if (cycles - last_ren !== rl) begin
                bad++;
                $display("FAIL cmp_latency: cycle %0d gap %0d required %0d", cycles, cycles - last_ren, rl);
              end
            end
          end
        end
      end
      if (o_ren === 1'b1) last_ren = cycles;
      start = (cycles == restart_at);
      abort = (cycles == abort_at);
      cycles++;
      @(negedge clk);
    end
    start = 1'b0;
    abort = 1'b0;
    total++;
    if (cycles >= 4000) begin
      bad++;
      $display("FAIL busy_timeout: busy still %0b after %0d cycles", o_busy, cycles);
    end
    if (abort_at < 0) begin
      total++;
      if (q.size() != 0) begin
        bad++;
        $display("FAIL missing_access: %0d accesses not issued, required 0", q.size());
      end
    end
  endtask

  task automatic test_reset();
    logic [74:0] obs;
    for (int k = 0; k < 2; k++) begin
      obs = {busy[k], done[k], fail[k], fail_addr[k], fail_elem[k], err_count[k],
             wen[k], ren[k], be[k], addr[k], wdata[k]};
      total++;
      if (obs !== '0) begin
        bad++;
        $display("FAIL reset_outputs[%0d]: got %h required 0", k, obs);
      end
    end
  endtask

  task automatic test_clean();
    int cyc;
    f_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      sel = k;
      run_march(-1, -1, cyc);
      total++;
      if (cyc !== busy_len(k == 1 ? 3 : 1)) begin
        bad++;
        $display("FAIL busy_cycles[%0d]: got %0d required %0d", k, cyc, busy_len(k == 1 ? 3 : 1));
      end
      total++;
      if ({o_done, o_fail, o_err} !== {1'b1, 1'b0, 8'd0}) begin
        bad++;
        $display("FAIL clean_status[%0d]: done=%0b fail=%0b err=%0d required 1 0 0", k, o_done, o_fail, o_err);
      end
    end
  endtask

  task automatic test_stuck_word5();
    int cyc;
    sel = 0;
    f_en = 1'b1; f_mask = 16'h0020; f_bit = 0; f_val = 1'b1;
    run_march(-1, -1, cyc);
    total++;
    if ({o_done, o_fail, o_fail_addr, o_fail_elem, o_err} !== {1'b1, 1'b1, 4'd5, 3'd1, 8'd3}) begin
      bad++;
      $display("FAIL stuck_word5: done=%0b fail=%0b addr=%0d elem=%0d err=%0d required 1 1 5 1 3",
               o_done, o_fail, o_fail_addr, o_fail_elem, o_err);
    end
    f_en = 1'b0;
  endtask

  task automatic test_random_faults();
    int cyc, exp_err, exp_fa, exp_fe;
    bit found, pat;
    for (int it = 0; it < 6; it++) begin
      sel = int'($urandom_range(0, 1));
      f_en = 1'b1;
      f_mask = D'($urandom_range(1, 16'hFFFF));
      f_bit = int'($urandom_range(0, DW - 1));
      f_val = 1'($urandom_range(0, 1));
      exp_err = 0; exp_fa = 0; exp_fe = 0; found = 1'b0;
      for (int el = 1; el <= 5; el++) begin
        pat = (el == 2 || el == 4);
        for (int i = 0; i < D; i++) begin
          int a;
          a = (el >= 3) ? D - 1 - i : i;
          if (f_mask[a] && f_val != pat) begin
            exp_err++;
            if (!found) begin
              found = 1'b1; exp_fa = a; exp_fe = el;
            end
          end
        end
      end
      if (exp_err > 255) exp_err = 255;
      run_march(-1, -1, cyc);
      total++;
      if ({o_done, o_fail, o_fail_addr, o_fail_elem, o_err} !==
          {1'b1, found, AW'(exp_fa), 3'(exp_fe), 8'(exp_err)}) begin
        bad++;
        $display("FAIL random_fault[%0d]: sel=%0d mask=%h bit=%0d val=%0b done=%0b fail=%0b addr=%0d elem=%0d err=%0d required 1 %0b %0d %0d %0d",
                 it, sel, f_mask, f_bit, f_val, o_done, o_fail, o_fail_addr, o_fail_elem, o_err,
                 found, exp_fa, exp_fe, exp_err);
      end
    end
    f_en = 1'b0;
  endtask

  task automatic test_abort();
    int cyc;
    sel = 0;
    f_en = 1'b1; f_mask = 16'h0004; f_bit = 7; f_val = 1'b1;
    run_march(-1, 40, cyc);
    total++;
    if ({cyc, o_busy, o_wen, o_ren, o_done, o_fail, o_err} !== {32'd41, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1}) begin
      bad++;
      $display("FAIL abort: cyc=%0d busy=%0b wen=%0b ren=%0b done=%0b fail=%0b err=%0d required 41 0 0 0 0 1 1",
               cyc, o_busy, o_wen, o_ren, o_done, o_fail, o_err);
    end
    abort = 1'b1; @(negedge clk); abort = 1'b0; @(negedge clk);
    total++;
    if ({o_busy, o_done, o_fail, o_err} !== {1'b0, 1'b0, 1'b1, 8'd1}) begin
      bad++;
      $display("FAIL abort_idle: busy=%0b done=%0b fail=%0b err=%0d required 0 0 1 1", o_busy, o_done, o_fail, o_err);
    end
    f_en = 1'b0;
    run_march(-1, -1, cyc);
    total++;
    if ({o_done, o_fail, o_err} !== {1'b1, 1'b0, 8'd0}) begin
      bad++;
      $display("FAIL after_abort: done=%0b fail=%0b err=%0d required 1 0 0", o_done, o_fail, o_err);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    sel = 1;
    run_march(50, -1, cyc);
    total++;
    if ({cyc, o_done} !== {32'(busy_len(3)), 1'b1}) begin
      bad++;
      $display("FAIL start_while_busy: cyc=%0d done=%0b required %0d 1", cyc, o_done, busy_len(3));
    end
    sel = 0;
    run_march(-1, -1, cyc);
    total++;
    if ({cyc, o_done, o_fail} !== {32'(busy_len(1)), 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL back_to_back: cyc=%0d done=%0b fail=%0b required %0d 1 0", cyc, o_done, o_fail, busy_len(1));
    end
  endtask

  task automatic test_reset_midrun();
    logic [74:0] obs;
    sel = 0;
    f_en = 1'b1; f_mask = 16'h0008; f_bit = 3; f_val = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (90) @(negedge clk);
    total++;
    if ({o_busy, o_fail} !== 2'b11) begin
      bad++;
      $display("FAIL pre_reset: busy=%0b fail=%0b required 1 1", o_busy, o_fail);
    end
    #1 rst_n = 1'b0;
    #1;
    obs = {o_busy, o_done, o_fail, o_fail_addr, o_fail_elem, o_err, o_wen, o_ren, o_be, o_addr, o_wdata};
    total++;
    if (obs !== '0) begin
      bad++;
      $display("FAIL async_reset: got %h required 0", obs);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    f_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total++;
      if ({o_busy, o_wen, o_ren} !== 3'b000) begin
        bad++;
        $display("FAIL post_reset_idle: cycle %0d busy=%0b wen=%0b ren=%0b required 0 0 0", i, o_busy, o_wen, o_ren);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; sel = 0;
    f_en = 1'b0; f_mask = '0; f_bit = 0; f_val = 1'b0;
    #12;
    test_reset();
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    test_clean();
    test_stuck_word5();
    test_random_faults();
    test_abort();
    test_back_to_back();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
